// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel plus
// the decode-side valid/ready handshake. The master modport is the fetch
// stage; the slave modport is its environment (memory + decode).
interface fetch_queue_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_rsp_valid;
  logic [INSTR_W-1:0] mem_rsp_data;
  logic               id_valid;
  logic               id_ready;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;

  modport master (
    output mem_req_valid, mem_req_addr, id_valid, id_pc, id_instr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, id_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, id_valid, id_pc, id_instr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues sequential word
// requests to an in-order variable-latency memory, buffers returned
// instructions with their PCs in a DEPTH-entry prefetch queue for decode,
// and flushes/squashes on redirects from decode.
// Optional build macro FETCH_PERF_CNT_EN adds saturating perf counters
// perf_redirects and perf_stall_cycles.
module fetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter int                 DEPTH    = 4,
  parameter int                 MAX_OUT  = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_queue_if.master     bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_redirects,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [ADDR_W-1:0] BOOT_PC = {RESET_PC[ADDR_W-1:2], 2'b00};
  localparam logic [ADDR_W-1:0] WORD    = ADDR_W'(4);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  rsp_pc;        // PC of the next non-squashed response
  logic [OUT_W-1:0]   outstanding, outstanding_nxt;
  logic [OUT_W-1:0]   squash;        // stale responses still to be dropped
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic              req_valid, credit_ok, credit_blocked;
  logic              hs, pop, push, rsp;
  logic [CNT_W:0]    in_flight;
  logic [ADDR_W-1:0] redirect_al;

  assign redirect_al = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign rsp         = bus.mem_rsp_valid;
  // Credit rule: every queued or in-flight instruction owns a queue slot.
  assign in_flight   = {1'b0, count} + (CNT_W+1)'(outstanding);
  assign credit_ok   = (outstanding < OUT_W'(MAX_OUT)) &&
                       (in_flight < (CNT_W+1)'(DEPTH));

  // FSM next state and request decision.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt      = state;
    req_valid      = 1'b0;
    credit_blocked = 1'b0;
    case (state)
      BOOT:   state_nxt = RUN;
      RUN: begin
        if (halt) begin
          state_nxt = HALTED;
        end else if (!redirect) begin
          req_valid      = credit_ok;
          credit_blocked = !credit_ok;
        end
      end
      HALTED: if (!halt) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  assign hs   = req_valid && bus.mem_req_ready;
  assign pop  = bus.id_valid && bus.id_ready;
  // A response in a redirect cycle belongs to the old stream and is dropped.
  assign push = rsp && (squash == '0) && !redirect;

  // Outstanding-request count after this cycle's handshake and response.
  always_comb begin
    outstanding_nxt = outstanding;
    case ({hs, rsp})
      2'b10:   outstanding_nxt = outstanding + OUT_W'(1);
      2'b01:   outstanding_nxt = outstanding - OUT_W'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // Fetch PC, response PC tracker, outstanding and squash counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= BOOT_PC;
      rsp_pc      <= BOOT_PC;
      outstanding <= '0;
      squash      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        fetch_pc <= redirect_al;
        rsp_pc   <= redirect_al;
        // Everything still in flight after this cycle belongs to the old stream.
        squash   <= outstanding_nxt;
      end else begin
        if (hs)                     fetch_pc <= fetch_pc + WORD;
        if (push)                   rsp_pc   <= rsp_pc + WORD;
        if (rsp && squash != '0)    squash   <= squash - OUT_W'(1);
      end
    end
  end

  // Prefetch queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Prefetch queue storage.
  // NOTE: storage is deliberately not reset; occupancy is tracked by count,
  // and the outputs are gated so unwritten entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= bus.mem_rsp_data;
    end
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc;
  assign bus.id_valid      = (count != '0);
  assign bus.id_pc         = bus.id_valid ? pc_mem[rd_ptr]    : '0;
  assign bus.id_instr      = bus.id_valid ? instr_mem[rd_ptr] : '0;

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters for redirects and issue stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (redirect && perf_redirects != '1)
        perf_redirects <= perf_redirects + 32'd1;
      if (((state == RUN) && req_valid && !bus.mem_req_ready) || credit_blocked)
        if (perf_stall_cycles != '1)
          perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: an in-order variable-latency memory
// model, a stream-level scoreboard (decode must see a contiguous word
// stream starting at the last redirect target), table-driven reset-release
// vectors, directed corner sequences and a randomized run.
module tb_fetch_queue;
  localparam int          ADDR_W   = 32;
  localparam int          INSTR_W  = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk, rst_n, halt, redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects, perf_stall_cycles;
`endif

  fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  fetch_queue #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
    .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    , .perf_redirects(perf_redirects), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_1234;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc, last_due, lat;
  logic [31:0] exp_req_addr, exp_id_pc;
  logic        obs_req_valid, obs_id_valid, obs_hs, obs_pop;
  logic [31:0] obs_req_addr, obs_id_pc, obs_id_instr;

  // One clock cycle: drive inputs at the falling edge, sample just after,
  // score the cycle, then advance the memory and stream models to match
  // what the DUT commits at the following rising edge.
  task automatic tick(input logic h, input logic rd, input logic [31:0] rpc,
                      input logic rdy, input logic idr);
    logic rsp;
    int   due;
    @(negedge clk);
    halt = h; redirect = rd; redirect_pc = rpc;
    bus.mem_req_ready = rdy; bus.id_ready = idr;
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.mem_rsp_valid = rsp;
    bus.mem_rsp_data  = rsp ? instr_of(mq[0].addr) : 32'd0;
    #1;
    obs_req_valid = bus.mem_req_valid;
    obs_req_addr  = bus.mem_req_addr;
    obs_id_valid  = bus.id_valid;
    obs_id_pc     = bus.id_pc;
    obs_id_instr  = bus.id_instr;
    obs_hs        = obs_req_valid && rdy;
    obs_pop       = obs_id_valid && idr;
    if (h || rd) check("req_blocked", 32'(obs_req_valid), 32'd0);
    if (obs_req_valid) begin
      check("req_addr", obs_req_addr, exp_req_addr);
      check("req_limit", 32'(mq.size() < MAX_OUT), 32'd1);
    end
    if (obs_pop) begin
      check("id_pc", obs_id_pc, exp_id_pc);
      check("id_instr", obs_id_instr, instr_of(exp_id_pc));
      exp_id_pc = exp_id_pc + 32'd4;
    end
    if (rsp) void'(mq.pop_front());
    if (obs_hs) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: obs_req_addr, due: due});
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (rd) begin
      exp_req_addr = {rpc[31:2], 2'b00};
      exp_id_pc    = {rpc[31:2], 2'b00};
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = 32'd0; bus.id_ready = 1'b0;
    mq.delete(); last_due = 0; cyc = 0;
    exp_req_addr = RESET_PC; exp_id_pc = RESET_PC;
    #1;
    check("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_req_addr", bus.mem_req_addr, RESET_PC);
    check("rst_id_valid", 32'(bus.id_valid), 32'd0);
    check("rst_id_pc", bus.id_pc, 32'd0);
    check("rst_id_instr", bus.id_instr, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rdy, idr;
    logic        e_req_valid;
    logic [31:0] e_req_addr;
    logic        e_id_valid;
    logic [31:0] e_id_pc;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    int          n_hs, n_pop, found;
    logic [31:0] hs_addrs[$];

    rst_n = 1'b0;

    // Reset release: BOOT cycle, first request in the second cycle, then a
    // 1-cycle-latency stream reaching decode in order.
    vecs[0] = '{1, 1, 0, 32'h0040_0000, 0, 32'h0};
    vecs[1] = '{1, 1, 1, 32'h0040_0000, 0, 32'h0};
    vecs[2] = '{1, 1, 1, 32'h0040_0004, 0, 32'h0};
    vecs[3] = '{1, 1, 1, 32'h0040_0008, 1, 32'h0040_0000};
    vecs[4] = '{1, 1, 1, 32'h0040_000C, 1, 32'h0040_0004};
    vecs[5] = '{1, 1, 1, 32'h0040_0010, 1, 32'h0040_0008};
    lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 32'd0, vecs[i].rdy, vecs[i].idr);
      check($sformatf("v%0d_req_valid", i), 32'(obs_req_valid), 32'(vecs[i].e_req_valid));
      check($sformatf("v%0d_req_addr", i), obs_req_addr, vecs[i].e_req_addr);
      check($sformatf("v%0d_id_valid", i), 32'(obs_id_valid), 32'(vecs[i].e_id_valid));
      check($sformatf("v%0d_id_pc", i), obs_id_pc, vecs[i].e_id_pc);
    end

    // Decode stalled: the credit rule allows exactly DEPTH requests, then
    // a single pop frees exactly one more.
    lat = 1;
    do_reset();
    n_hs = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      if (obs_hs) n_hs++;
    end
    check("fill_requests", 32'(n_hs), 32'd4);
    check("fill_blocked", 32'(obs_req_valid), 32'd0);
    tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    n_hs = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      if (obs_hs) n_hs++;
    end
    check("fill_one_more", 32'(n_hs), 32'd1);

    // Redirect with three requests in flight and none returned yet.
    lat = 4;
    do_reset();
    n_hs = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      if (obs_hs) n_hs++;
    end
    check("squash3_inflight", 32'(n_hs), 32'd3);
    tick(1'b0, 1'b1, 32'h0040_0100, 1'b1, 1'b1);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      if (obs_id_valid) found = 1;
    end
    check("squash3_seen", 32'(found), 32'd1);
    if (found == 1) check("squash3_first_pc", obs_id_pc, 32'h0040_0100);

    // Redirect coinciding with a response and with a decode pop.
    lat = 2;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 32'h0040_0202, 1'b1, 1'b1);
    check("coinc_pop_valid", 32'(obs_id_valid), 32'd1);
    check("coinc_pop_pc", obs_id_pc, 32'h0040_0000);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      if (obs_id_valid) found = 1;
    end
    check("coinc_seen", 32'(found), 32'd1);
    if (found == 1) begin
      check("coinc_first_pc", obs_id_pc, 32'h0040_0200);
      check("coinc_first_instr", obs_id_instr, instr_of(32'h0040_0200));
    end

    // Halt for 10 cycles with a toggling ready: no handshakes, in-flight
    // responses drain to decode, then fetch resumes sequentially.
    lat = 3;
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    n_hs = 0; n_pop = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 32'd0, 1'(i % 2), 1'b1);
      if (obs_hs) n_hs++;
      if (obs_pop) n_pop++;
    end
    check("halt_no_hs", 32'(n_hs), 32'd0);
    check("halt_drained", 32'(n_pop >= 1), 32'd1);
    check("halt_queue_empty", 32'(obs_id_valid), 32'd0);
    tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check("halt_exit_idle", 32'(obs_req_valid), 32'd0);
    tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check("halt_resume_valid", 32'(obs_req_valid), 32'd1);
    check("halt_resume_addr", obs_req_addr, 32'h0040_0010);

    // Address wrap at the top of the space; two redirects in total.
    lat = 1;
    do_reset();
    tick(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1, 1'b1);
    hs_addrs.delete();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      if (obs_hs) hs_addrs.push_back(obs_req_addr);
    end
    check("wrap_count", 32'(hs_addrs.size() >= 3), 32'd1);
    if (hs_addrs.size() >= 3) begin
      check("wrap_a0", hs_addrs[0], 32'hFFFF_FFF8);
      check("wrap_a1", hs_addrs[1], 32'hFFFF_FFFC);
      check("wrap_a2", hs_addrs[2], 32'h0000_0000);
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_redirects", perf_redirects, 32'd2);
`endif

    // Randomized traffic scored against the stream model.
    do_reset();
    n_pop = 0;
    for (int i = 0; i < 3000; i++) begin
      lat = int'($urandom_range(5, 1));
      tick(1'($urandom_range(99) < 8), 1'($urandom_range(99) < 5), $urandom(),
           1'($urandom_range(99) < 70), 1'($urandom_range(99) < 60));
      if (obs_pop) n_pop++;
    end
    check("rand_progress", 32'(n_pop > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
